// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and helpers for the banked data memory.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Widest load result the extension helper handles; callers cast to DATA_W.
    localparam int c_EXT_W = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    function automatic int bytes_of(input size_e size);
        return 1 << int'(size);
    endfunction

    function automatic logic [c_EXT_W-1:0] ext(input logic [c_EXT_W-1:0] data,
                                               input size_e              size,
                                               input logic               uns);
        logic [c_EXT_W-1:0] res;
        logic               sgn;
        res = data;
        sgn = 1'b0;
        case (size)
            SZ_B: begin
                sgn = ~uns & data[7];
                res = {{(c_EXT_W-8){sgn}}, data[7:0]};
            end
            SZ_H: begin
                sgn = ~uns & data[15];
                res = {{(c_EXT_W-16){sgn}}, data[15:0]};
            end
            default: res = data;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane
//  Description : One byte lane: 8-bit x DEPTH RAM, synchronous write,
//                registered read.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_lane #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] r_mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= r_mem_q[addr_i];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_banked
//  Description : Byte-lane banked data memory; word-crossing accesses are
//                split into two beats, loads extended on the response.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int c_NB    = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);
    localparam int c_WI_W  = $clog2(DEPTH);

    state_e              r_state_q, w_state_d;
    logic                r_rsp_valid_q, w_rsp_valid_d;
    logic                r_rsp_err_q, w_rsp_err_d;

    logic [c_WI_W-1:0]   w_wi, w_lane_addr, r_wi1_q;
    logic [c_OFF_W-1:0]  w_off, r_off_q;
    size_e               w_size, r_size_q;
    logic                w_legal, w_cross, w_accept;
    int                  w_span;
    logic [c_NB-1:0]     w_mask1, w_mask2, r_mask2_q, w_lane_we;
    logic [DATA_W-1:0]   w_rot, r_wrot_q, w_lane_wdata, w_lane_rdata;
    logic [DATA_W-1:0]   r_stage_q, w_merge, w_asm;
    logic                r_uns_q, r_we_q, r_cross_q;

    assign w_wi   = req_addr_i[ADDR_W-1:c_OFF_W];
    assign w_off  = req_addr_i[c_OFF_W-1:0];
    assign w_size = size_e'(req_size_i);

    assign req_ready_o = (r_state_q == ST_IDLE);
    assign w_accept    = req_valid_i & (r_state_q == ST_IDLE) & ~rst_i;

    // Beat-1 lanes sit at or above the offset; wrapped lanes belong to word wi+1.
    always_comb begin
        w_span  = int'(w_off) + bytes_of(w_size);
        w_legal = (w_size != SZ_X) && (bytes_of(w_size) <= c_NB);
        w_cross = (w_span > c_NB);
        for (int l = 0; l < c_NB; l++) begin
            w_mask1[l]       = (l >= int'(w_off)) && (l < w_span);
            w_mask2[l]       = ((l + c_NB) < w_span);
            w_rot[8*l +: 8]  = req_wdata_i[8*((l - int'(w_off)) & (c_NB-1)) +: 8];
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_rsp_valid_d = 1'b0;
        w_rsp_err_d   = 1'b0;
        w_lane_we     = '0;
        w_lane_addr   = w_wi;
        w_lane_wdata  = w_rot;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rsp_valid_d = ~(w_legal & w_cross);
                    w_rsp_err_d   = ~w_legal;
                    if (w_legal && w_cross) begin
                        w_state_d = ST_SECOND;
                    end
                    if (w_legal && req_we_i) begin
                        w_lane_we = w_mask1;
                    end
                end
            end
            ST_SECOND: begin
                w_state_d     = ST_IDLE;
                w_rsp_valid_d = 1'b1;
                w_lane_addr   = r_wi1_q;
                w_lane_wdata  = r_wrot_q;
                if (r_we_q) begin
                    w_lane_we = r_mask2_q;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        // A reset landing on beat 2 must not commit it.
        if (rst_i) begin
            w_lane_we = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= ST_IDLE;
            r_rsp_valid_q <= 1'b0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    // Request attributes stay valid until the response cycle that uses them.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_wi1_q   <= w_wi + c_WI_W'(1);
            r_off_q   <= w_off;
            r_size_q  <= w_size;
            r_uns_q   <= req_unsigned_i;
            r_we_q    <= req_we_i;
            r_cross_q <= w_legal & w_cross;
            r_mask2_q <= w_mask2;
            r_wrot_q  <= w_rot;
        end
        if (r_state_q == ST_SECOND) begin
            r_stage_q <= w_lane_rdata;
        end
    end

    for (genvar g = 0; g < c_NB; g++) begin : g_lane
        dmem_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk_i   (clk_i),
            .we_i    (w_lane_we[g]),
            .addr_i  (w_lane_addr),
            .wdata_i (w_lane_wdata[8*g +: 8]),
            .rdata_o (w_lane_rdata[8*g +: 8])
        );
    end

    always_comb begin
        for (int l = 0; l < c_NB; l++) begin
            w_merge[8*l +: 8] = (r_cross_q && (l >= int'(r_off_q))) ? r_stage_q[8*l +: 8]
                                                                    : w_lane_rdata[8*l +: 8];
        end
        for (int l = 0; l < c_NB; l++) begin
            w_asm[8*l +: 8] = w_merge[8*((l + int'(r_off_q)) & (c_NB-1)) +: 8];
        end
    end

    assign rsp_valid_o = r_rsp_valid_q;
    assign rsp_err_o   = r_rsp_err_q;
    assign rsp_rdata_o = (r_rsp_valid_q && !r_rsp_err_q && !r_we_q)
                       ? DATA_W'(ext(c_EXT_W'(w_asm), r_size_q, r_uns_q))
                       : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_banked
//  Description : Directed bench for dmem_banked with a byte-array reference
//                memory and an expected-response queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_banked;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 14;
    localparam int MEMB   = 16384;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [1:0]        req_size_i = '0;
    logic              req_unsigned_i = 1'b0;
    logic [DATA_W-1:0] req_wdata_i = '0;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    dmem_banked #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned edge_cnt = 0;
    int unsigned cross_edge = 32'hFFFF_FFFF;
    bit          chk_en = 1'b0;
    int          issued = 0;
    int          rsp_seen = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [7:0]  mdl_mem [MEMB];
    rsp_t        exp_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // Reference: flat byte memory, in-order responses, fixed latencies.
    function automatic void mdl_accept(input logic we, input logic [13:0] a, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] wd, input int unsigned e);
        rsp_t        r;
        int          n;
        int          ai;
        logic [31:0] v;
        ai     = int'(a);
        r.err  = 1'b0;
        r.data = '0;
        r.due  = e + 1;
        if (sz == 2'd3) begin
            r.err = 1'b1;
        end else begin
            n = 1 << sz;
            if ((ai % 4) + n > 4) begin
                r.due      = e + 2;
                cross_edge = e + 1;
            end
            if (we) begin
                for (int k = 0; k < n; k++) mdl_mem[(ai + k) % MEMB] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mdl_mem[(ai + k) % MEMB];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                end
                r.data = v;
            end
        end
        exp_q.push_back(r);
        issued++;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, req_ready_o}, (edge_cnt == cross_edge) ? 32'd0 : 32'd1);
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                check("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
                check("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_q[0].err});
                check("rsp_rdata", rsp_rdata_o, exp_q[0].data);
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
                rsp_seen++;
                void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_quiet", {31'd0, rsp_valid_o}, 32'd0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [13:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = a;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_wdata_i    = wd;
        while (req_ready_o !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            checks++;
            errors++;
            $display("FAIL handshake: ready stuck %b required 1", req_ready_o);
            req_valid_i = 1'b0;
            return;
        end
        mdl_accept(we, a, sz, uns, wd, edge_cnt);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] exp);
        int g;
        g = 0;
        while (rsp_seen < issued && g < 10) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (rsp_seen < issued) begin
            checks++;
            errors++;
            $display("FAIL %s: response missing, seen %0d required %0d", nm, rsp_seen, issued);
        end else begin
            check(nm, last_rdata, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready_o}, 32'd1);
        check("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("reset_err", {31'd0, rsp_err_o}, 32'd0);
        check("reset_rdata", rsp_rdata_o, 32'd0);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // Basic word store/load, byte sign/zero extension
        do_req(1, 14'h0000, 2, 0, 32'h8899AABB);
        do_req(1, 14'h0004, 2, 0, 32'h03020100);
        do_req(1, 14'h0008, 2, 0, 32'h07060504);
        do_req(1, 14'h000C, 2, 0, 32'h0B0A0908);
        do_req(1, 14'h3FFC, 2, 0, 32'h77665544);
        do_req(0, 14'h0000, 2, 0, 32'h0);  lit("lw_0", 32'h8899AABB);
        do_req(0, 14'h0001, 0, 0, 32'h0);  lit("lb_1", 32'hFFFFFFAA);
        do_req(0, 14'h0001, 0, 1, 32'h0);  lit("lbu_1", 32'h000000AA);

        // Halfword store preserves neighbours
        do_req(1, 14'h0002, 1, 0, 32'h00001234);
        do_req(0, 14'h0000, 2, 0, 32'h0);  lit("lw_after_sh", 32'h1234AABB);
        do_req(0, 14'h0002, 1, 0, 32'h0);  lit("lh_2", 32'h00001234);
        do_req(0, 14'h0003, 0, 0, 32'h0);  lit("lb_3", 32'h00000012);

        // Word-crossing store and loads
        do_req(1, 14'h0007, 2, 0, 32'hDEADBEEF);
        do_req(0, 14'h0004, 2, 0, 32'h0);  lit("lw_4", 32'hEF020100);
        do_req(0, 14'h0008, 2, 0, 32'h0);  lit("lw_8", 32'h07DEADBE);
        do_req(0, 14'h0007, 2, 0, 32'h0);  lit("lw_7_cross", 32'hDEADBEEF);

        // Wrap from top of memory to word 0
        do_req(1, 14'h3FFF, 1, 0, 32'h0000A55A);
        do_req(0, 14'h3FFF, 1, 0, 32'h0);  lit("lh_wrap", 32'hFFFFA55A);
        do_req(0, 14'h0000, 0, 1, 32'h0);  lit("lbu_0_wrap", 32'h000000A5);
        do_req(0, 14'h3FFF, 0, 1, 32'h0);  lit("lbu_3fff", 32'h0000005A);
        do_req(0, 14'h0003, 1, 0, 32'h0);  lit("lh_3_cross", 32'h00000012);

        // Reset while beat 2 of a crossing store is pending
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 14'h0005;
        req_size_i = 2'd2; req_unsigned_i = 1'b0; req_wdata_i = 32'h11223344;
        check("rst_test_ready", {31'd0, req_ready_o}, 32'd1);
        e = edge_cnt;
        cross_edge = e + 1;
        mdl_mem[5] = 8'h44; mdl_mem[6] = 8'h33; mdl_mem[7] = 8'h22;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        do_req(0, 14'h0004, 2, 0, 32'h0);  lit("lw_4_partial", 32'h22334400);
        do_req(0, 14'h0008, 0, 1, 32'h0);  lit("lbu_8_kept", 32'h000000BE);

        // Illegal size: error response, memory untouched
        do_req(1, 14'h0004, 3, 0, 32'hFFFFFFFF);
        lit("illegal_st_rdata", 32'h0);
        check("illegal_st_err", {31'd0, last_err}, 32'd1);
        do_req(0, 14'h0004, 3, 0, 32'h0);
        lit("illegal_ld_rdata", 32'h0);
        do_req(0, 14'h0004, 2, 0, 32'h0);  lit("lw_4_intact", 32'h22334400);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
